// File: rtl/gray_sobel_edge.sv
// gray_sobel_edge: streaming 3x3 Sobel edge detector on the low gray byte of a 24-bit bus.
// Ports: clk/rst (sync, active-high); din/de_in/hs_in/vs_in video in; thresh, edge_en runtime
//        controls (latched at frame start); dout/de_out/hs_out/vs_out video out, 4-clock latency.
module gray_sobel_edge #(
   parameter int          H_ACTIVE   = 1280,
   parameter bit          VS_POL     = 1'b1,
   parameter logic [10:0] DEF_THRESH = 11'd200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] din,
   input  logic        de_in,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic [10:0] thresh,
   input  logic        edge_en,
   output logic [23:0] dout,
   output logic        de_out,
   output logic        hs_out,
   output logic        vs_out
);

   localparam int            CW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam logic [CW-1:0] COL_MAX = CW'(H_ACTIVE - 1);

   // upper bytes of the replicated gray bus carry no extra information
   logic unused_din;
   assign unused_din = ^din[23:8];

   // ---------------- frame / line tracking ----------------
   logic          de_prev, vs_prev, row_ok, vs_act, frame_start;
   logic [CW-1:0] col_reg, col_cur;
   logic [10:0]   row_reg, row_cur;
   logic [10:0]   thr_act;
   logic          en_act;

   assign vs_act      = (vs_in == VS_POL);
   assign frame_start = vs_act && !vs_prev;

   // position of the pixel presented this cycle; a frame start wins over everything
   always_comb begin
      col_cur = col_reg;
      if (frame_start || (de_in && !de_prev))
         col_cur = '0;
      else if (col_reg != COL_MAX)
         col_cur = col_reg + CW'(1);
      row_cur = frame_start ? 11'd0 : row_reg;
   end

   // vs_prev resets to "active" so a vs held active through reset is not a frame start.
   // row_ok stays low after reset until a real frame start, pinning rows at 0 (all masked).
   always_ff @(posedge clk) begin
      if (rst) begin
         de_prev <= 1'b0;
         vs_prev <= 1'b1;
         row_ok  <= 1'b0;
         col_reg <= '0;
         row_reg <= '0;
         thr_act <= DEF_THRESH;
         en_act  <= 1'b1;
      end else begin
         de_prev <= de_in;
         vs_prev <= vs_act;
         if (de_in)
            col_reg <= col_cur;
         if (frame_start) begin
            row_reg <= '0;
            row_ok  <= 1'b1;
            thr_act <= thresh;
            en_act  <= edge_en;
         end else if (de_prev && !de_in && row_ok && (row_reg != 11'h7FF)) begin
            row_reg <= row_reg + 11'd1;
         end
      end
   end

   // ---------------- line buffers (read-before-write, not reset) ----------------
   logic [7:0] lb1 [0:H_ACTIVE-1];
   logic [7:0] lb2 [0:H_ACTIVE-1];
   logic [7:0] rd1, rd2;

   always_ff @(posedge clk) begin
      if (de_in) begin
         rd1          <= lb1[col_cur];
         rd2          <= lb2[col_cur];
         lb1[col_cur] <= din[7:0];
         lb2[col_cur] <= lb1[col_cur];
      end
   end

   // ---------------- pipeline ----------------
   // s1..s3 hold {de,hs,vs}; the output registers form the fourth stage.
   logic [2:0] s1, s2, s3;
   logic [7:0] pix1, pix2, e3;
   logic       brd1, brd2;
   logic [7:0] win [0:2][0:2];   // [row r-2..r][col c-2..c]

   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= '0;
         s2   <= '0;
         s3   <= '0;
         pix1 <= '0;
         pix2 <= '0;
         brd1 <= 1'b1;
         brd2 <= 1'b1;
         e3   <= '0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               win[i][j] <= '0;
         dout   <= '0;
         de_out <= 1'b0;
         hs_out <= 1'b0;
         vs_out <= 1'b0;
      end else begin
         // stage 1: line-buffer read, position classification
         s1   <= {de_in, hs_in, vs_in};
         pix1 <= din[7:0];
         brd1 <= (row_cur < 11'd2) || (col_cur < CW'(2));
         // stage 2: window shift on valid pixels
         s2   <= s1;
         pix2 <= pix1;
         brd2 <= brd1;
         if (s1[2]) begin
            for (int i = 0; i < 3; i++) begin
               win[i][0] <= win[i][1];
               win[i][1] <= win[i][2];
            end
            win[0][2] <= rd2;
            win[1][2] <= rd1;
            win[2][2] <= pix1;
         end
         // stage 3: gradient decision or bypass
         s3 <= s2;
         if (!en_act)
            e3 <= pix2;
         else if (brd2)
            e3 <= 8'h00;
         else
            e3 <= (g > thr_act) ? 8'hFF : 8'h00;
         // stage 4: output, blanked outside de
         dout   <= s3[2] ? {3{e3}} : 24'd0;
         de_out <= s3[2];
         hs_out <= s3[1];
         vs_out <= s3[0];
      end
   end

   // ---------------- Sobel arithmetic on the window ----------------
   logic [9:0]         gx_p, gx_n, gy_p, gy_n;
   logic signed [10:0] gx, gy;
   logic [10:0]        ax, ay, g;

   always_comb begin
      gx_p = {2'b0, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b0, win[2][2]};
      gx_n = {2'b0, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b0, win[2][0]};
      gy_p = {2'b0, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b0, win[2][2]};
      gy_n = {2'b0, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b0, win[0][2]};
      gx   = $signed({1'b0, gx_p}) - $signed({1'b0, gx_n});
      gy   = $signed({1'b0, gy_p}) - $signed({1'b0, gy_n});
      ax   = gx[10] ? $unsigned(-gx) : $unsigned(gx);
      ay   = gy[10] ? $unsigned(-gy) : $unsigned(gy);
      g    = ax + ay;   // at most 2040
   end

endmodule

// File: tb/tb_gray_sobel_edge.sv
module tb_gray_sobel_edge;

   localparam int H = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] din;
   logic        de_in, hs_in, vs_in;
   logic [10:0] thresh;
   logic        edge_en;
   logic [23:0] dout;
   logic        de_out, hs_out, vs_out;

   gray_sobel_edge #(.H_ACTIVE(H), .VS_POL(1'b1), .DEF_THRESH(11'd200)) dut (
      .clk(clk), .rst(rst), .din(din), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
      .thresh(thresh), .edge_en(edge_en),
      .dout(dout), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // expected output modes: 0 all black, 1 vertical step edge at columns 8/9, 2 ramp bypass
   int exp_mode = 0;
   bit mon_en   = 0;
   int n_de     = 0;

   function automatic logic [23:0] exp_px(input int mode, input int r, input int c);
      logic [7:0] p;
      p = 8'(c);
      case (mode)
         1:       exp_px = (r >= 2 && (c == 8 || c == 9)) ? 24'hFFFFFF : 24'h000000;
         2:       exp_px = {p, p, p};
         default: exp_px = 24'h000000;
      endcase
   endfunction

   // output-side monitor: tracks output row/col from the delayed syncs
   int  orow = 0, ocol = 0;
   bit  de_q = 0, vs_q = 0;
   always @(negedge clk) begin
      if (vs_out && !vs_q) orow = 0;
      if (de_out) begin
         if (!de_q) ocol = 0;
         else       ocol++;
         if (mon_en) begin
            check($sformatf("px r%0d c%0d m%0d", orow, ocol, exp_mode), dout,
                  exp_px(exp_mode, orow, ocol));
            n_de++;
         end
      end else begin
         if (de_q) orow++;
         if (mon_en) check("idle_dout", dout, 0);
      end
      de_q = de_out;
      vs_q = vs_out;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pix_of(input int pat, input int c);
      case (pat)
         1:       pix_of = (c < 8) ? 8'd0 : 8'd100;
         2:       pix_of = 8'(c);
         default: pix_of = 8'h55;
      endcase
   endfunction

   // one frame: vs pulse, then 'lines' lines of H pixels; optional reset at (rst_row, col 5..7)
   // and optional threshold change at the start of thr_row
   task automatic drive_frame(input int pat, input int lines, input int rst_row,
                              input int thr_row, input logic [10:0] thr_new);
      logic [7:0] p;
      vs_in = 1'b1; cyc(); cyc();
      vs_in = 1'b0; repeat (3) cyc();
      for (int r = 0; r < lines; r++) begin
         for (int c = 0; c < H; c++) begin
            if (r == thr_row && c == 0) thresh = thr_new;
            rst = (r == rst_row) && (c >= 5) && (c < 8);
            if (rst) exp_mode = 0;
            p     = pix_of(pat, c);
            de_in = 1'b1;
            din   = {p, p, p};
            cyc();
         end
         rst   = 1'b0;
         de_in = 1'b0;
         din   = '0;
         hs_in = 1'b1; cyc(); cyc();
         hs_in = 1'b0; cyc(); cyc();
      end
      repeat (8) cyc();
   endtask

   logic [2:0] hist [0:15];

   initial begin
      rst = 1'b1; din = '0; de_in = 0; hs_in = 0; vs_in = 0;
      thresh = 11'd200; edge_en = 1'b1;

      // reset with random inputs
      for (int i = 0; i < 3; i++) begin
         din = 24'($urandom);
         {de_in, hs_in, vs_in} = 3'($urandom_range(0, 7));
         cyc();
         check("rst_dout", dout, 0);
         check("rst_sync", {de_out, hs_out, vs_out}, 0);
      end
      rst = 1'b0;

      // sync latency: output after edge i reflects inputs driven before edge i-3
      for (int i = 0; i < 16; i++) begin
         hist[i] = 3'($urandom_range(0, 7));
         {de_in, hs_in, vs_in} = hist[i];
         din = 24'($urandom);
         cyc();
         if (i >= 3) check($sformatf("lat%0d", i), {de_out, hs_out, vs_out}, hist[i-3]);
         else        check($sformatf("lat_fill%0d", i), {de_out, hs_out, vs_out}, 0);
      end
      {de_in, hs_in, vs_in} = 3'b000;
      din = '0;
      repeat (8) cyc();

      mon_en = 1;

      // flat frame
      exp_mode = 0; n_de = 0;
      drive_frame(0, 8, -1, -1, 11'd0);
      check("flat_de_cnt", n_de, 128);

      // vertical step, G = 400 > 200
      exp_mode = 1;
      drive_frame(1, 8, -1, -1, 11'd0);

      // G == threshold gives black
      thresh = 11'd400; exp_mode = 0;
      drive_frame(1, 8, -1, -1, 11'd0);

      // 399 latched; mid-frame change to 400 must not take effect
      thresh = 11'd399; exp_mode = 1;
      drive_frame(1, 8, -1, 3, 11'd400);

      // the 400 now takes effect
      exp_mode = 0;
      drive_frame(1, 8, -1, -1, 11'd0);

      // bypass ramp, borders not zeroed
      edge_en = 1'b0; exp_mode = 2;
      drive_frame(2, 3, -1, -1, 11'd0);
      edge_en = 1'b1; thresh = 11'd200;

      // reset mid-frame at row 4 column 5: black until next vs
      exp_mode = 1;
      drive_frame(1, 8, 4, -1, 11'd0);

      // following full frame is a normal step result
      exp_mode = 1; n_de = 0;
      drive_frame(1, 8, -1, -1, 11'd0);
      check("step_de_cnt", n_de, 128);

      mon_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
